// File: rtl/control_unit_pkg.sv
// Shared definitions for the accumulator control unit: widths, instruction fields,
// opcode values and FSM state encoding.
package control_unit_pkg;

    localparam int unsigned DataWDefault = 18;
    localparam int unsigned AddrWDefault = 13;

    // Instruction layout: opcode in [17:15], reserved [14:13], operand address [12:0].
    localparam int unsigned OpcodeMsb  = 17;
    localparam int unsigned OpcodeLsb  = 15;
    localparam int unsigned RsvdMsb    = 14;
    localparam int unsigned RsvdLsb    = 13;
    localparam int unsigned OperandMsb = 12;
    localparam int unsigned OperandLsb = 0;

    typedef enum logic [2:0] {
        OpAdd   = 3'b000,
        OpLoad  = 3'b001,
        OpStore = 3'b010,
        OpSub   = 3'b011,
        OpJmp   = 3'b100,
        OpJz    = 3'b101,
        OpHalt  = 3'b110,
        OpNop   = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StDecode  = 3'd1,
        StExecute = 3'd2,
        StAccum   = 3'd3,
        StHalt    = 3'd4
    } state_e;

    function automatic logic is_mem_read_op(opcode_e op);
        return (op == OpLoad) || (op == OpAdd) || (op == OpSub);
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Memory bus between the control unit (master) and a 1-cycle-latency memory (slave).
interface control_unit_if
    import control_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned ADDR_W = AddrWDefault
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] DataOut;
    logic              re_en;
    logic              wr_en;

    modport master (
        output address,
        output DataIn,
        output re_en,
        output wr_en,
        input  DataOut
    );

    modport slave (
        input  address,
        input  DataIn,
        input  re_en,
        input  wr_en,
        output DataOut
    );
endinterface

// File: rtl/cu_alu.sv
// Combinational accumulator datapath: pass (LOAD), add and subtract, wrapping mod 2^DATA_W.
module cu_alu
    import control_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic [DATA_W-1:0] ac_i,
    input  logic [DATA_W-1:0] operand_i,
    input  opcode_e           opcode_i,
    output logic [DATA_W-1:0] result_o
);

    always_comb begin
        result_o = ac_i;
        unique case (opcode_i)
            OpLoad:  result_o = operand_i;
            OpAdd:   result_o = ac_i + operand_i;
            OpSub:   result_o = ac_i - operand_i;
            default: result_o = ac_i;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle accumulator machine: FETCH/DECODE/EXECUTE/ACCUM/HALT sequencer driving a
// registered-read memory bus.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned ADDR_W = AddrWDefault
) (
    input  logic              clk,
    input  logic              rst,
    control_unit_if.master    mem,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ac,
    output logic              halted
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] alu_result;
    logic [ADDR_W-1:0] operand;
    opcode_e           opcode;
    logic              unused_rsvd;

    assign opcode      = opcode_e'(ir_q[OpcodeMsb:OpcodeLsb]);
    assign operand     = ir_q[ADDR_W-1:0];
    assign unused_rsvd = ^ir_q[RsvdMsb:RsvdLsb];

    cu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .ac_i      (ac_q),
        .operand_i (mem.DataOut),
        .opcode_i  (opcode),
        .result_o  (alu_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ac_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ac_q    <= ac_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ac_d    = ac_q;
        ir_d    = ir_q;
        unique case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                ir_d    = mem.DataOut;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = StExecute;
            end
            StExecute: begin
                unique case (opcode)
                    OpLoad, OpAdd, OpSub: state_d = StAccum;
                    OpJmp: begin
                        pc_d    = operand;
                        state_d = StFetch;
                    end
                    OpJz: begin
                        if (ac_q == '0) pc_d = operand;
                        state_d = StFetch;
                    end
                    OpHalt:  state_d = StHalt;
                    default: state_d = StFetch;
                endcase
            end
            StAccum: begin
                ac_d    = alu_result;
                state_d = StFetch;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // Strobes are gated by rst so an in-flight access is dropped the moment reset rises.
    always_comb begin
        mem.re_en   = 1'b0;
        mem.wr_en   = 1'b0;
        mem.address = (state_q == StExecute) ? operand : pc_q;
        mem.DataIn  = ac_q;
        if (!rst) begin
            unique case (state_q)
                StFetch: mem.re_en = 1'b1;
                StExecute: begin
                    mem.re_en = is_mem_read_op(opcode);
                    mem.wr_en = (opcode == OpStore);
                end
                default: ;
            endcase
        end
    end

    assign pc     = pc_q;
    assign ac     = ac_q;
    assign halted = (state_q == StHalt);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a 1-cycle-latency memory model.
module tb_control_unit;
    import control_unit_pkg::*;

    localparam int unsigned DW = 18;
    localparam int unsigned AW = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] pc;
    logic [DW-1:0] ac;
    logic          halted;

    int checks   = 0;
    int failures = 0;

    control_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    control_unit #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mem    (bus.master),
        .pc     (pc),
        .ac     (ac),
        .halted (halted)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (bus.re_en) bus.DataOut <= mem[bus.address];
        if (bus.wr_en) mem[bus.address] <= bus.DataIn;
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (bus.re_en && bus.wr_en) begin
                failures++;
                $display("FAIL strobe_exclusive: re_en=%0b wr_en=%0b required not both 1",
                         bus.re_en, bus.wr_en);
            end
            if (halted && (bus.re_en || bus.wr_en)) begin
                failures++;
                $display("FAIL halt_strobes: re_en=%0b wr_en=%0b required 0 while halted",
                         bus.re_en, bus.wr_en);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] enc(input opcode_e op, input logic [AW-1:0] a);
        return {op, 2'b00, a};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < (1 << AW); i++) mem[i] = enc(OpHalt, '0);
    endtask

    task automatic wait_halted(input string name);
        for (int i = 0; i < 300 && !halted; i++) step();
        check(name, 32'(halted), 32'd1);
    endtask

    typedef struct {
        string         name;
        logic [DW-1:0] i0, i1, i2, i3;
        logic [DW-1:0] d20, d21;
        logic [DW-1:0] exp_ac;
        logic [AW-1:0] exp_pc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{"add", enc(OpLoad, 20), enc(OpAdd, 21), enc(OpNop, 0), enc(OpNop, 0),
                    18'd42, 18'd3, 18'd45, 13'd5};
        vecs[1] = '{"sub_wrap", enc(OpLoad, 20), enc(OpSub, 21), enc(OpNop, 0), enc(OpNop, 0),
                    18'd3, 18'd5, 18'h3FFFE, 13'd5};
        vecs[2] = '{"add_wrap", enc(OpLoad, 20), enc(OpAdd, 21), enc(OpNop, 0), enc(OpNop, 0),
                    18'h3FFFF, 18'd2, 18'd1, 13'd5};
        vecs[3] = '{"jz_taken", enc(OpLoad, 20), enc(OpJz, 7), enc(OpNop, 0), enc(OpNop, 0),
                    18'd0, 18'd0, 18'd0, 13'd8};
        vecs[4] = '{"jz_not_taken", enc(OpLoad, 20), enc(OpJz, 7), enc(OpNop, 0), enc(OpNop, 0),
                    18'd1, 18'd0, 18'd1, 13'd5};
        vecs[5] = '{"jmp", enc(OpJmp, 10), enc(OpLoad, 20), enc(OpNop, 0), enc(OpNop, 0),
                    18'd9, 18'd0, 18'd0, 13'd11};
        vecs[6] = '{"rsvd_ignored", enc(OpLoad, 20) | 18'h06000, enc(OpSub, 20), enc(OpAdd, 21),
                    enc(OpNop, 0), 18'd5, 18'd9, 18'd9, 13'd5};
        vecs[7] = '{"store_reload", enc(OpLoad, 20), enc(OpStore, 22), enc(OpLoad, 21),
                    enc(OpAdd, 22), 18'd7, 18'd100, 18'd107, 13'd5};

        for (int v = 0; v < 8; v++) begin
            do_reset();
            clear_mem();
            mem[0]  = vecs[v].i0;
            mem[1]  = vecs[v].i1;
            mem[2]  = vecs[v].i2;
            mem[3]  = vecs[v].i3;
            mem[20] = vecs[v].d20;
            mem[21] = vecs[v].d21;
            rst = 1'b0;
            #1;
            wait_halted({vecs[v].name, "_halt"});
            check({vecs[v].name, "_ac"}, 32'(ac), 32'(vecs[v].exp_ac));
            check({vecs[v].name, "_pc"}, 32'(pc), 32'(vecs[v].exp_pc));
        end

        // V1: exact cycle timing of a four-instruction program; also reset values after a run.
        do_reset();
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ac", 32'(ac), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_strobes", {30'd0, bus.re_en, bus.wr_en}, 32'd0);
        clear_mem();
        mem[0]  = enc(OpLoad, 13);
        mem[1]  = enc(OpAdd, 14);
        mem[2]  = enc(OpStore, 15);
        mem[3]  = enc(OpHalt, 0);
        mem[13] = 18'd42;
        mem[14] = 18'd3;
        mem[15] = 18'd0;
        rst = 1'b0;
        #1;
        check("v1_c0_addr", 32'(bus.address), 32'd0);
        check("v1_c0_re", 32'(bus.re_en), 32'd1);
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c == 2) check("v1_c2_exec_addr", 32'(bus.address), 32'd13);
            if (c == 10) begin
                check("v1_c10_wr", 32'(bus.wr_en), 32'd1);
                check("v1_c10_addr", 32'(bus.address), 32'd15);
                check("v1_c10_data", 32'(bus.DataIn), 32'd45);
                check("v1_c10_mem_before", 32'(mem[15]), 32'd0);
            end
            if (c == 11) check("v1_c11_mem", 32'(mem[15]), 32'd45);
            if (c == 13) check("v1_c13_halted", 32'(halted), 32'd0);
            if (c == 14) begin
                check("v1_c14_halted", 32'(halted), 32'd1);
                check("v1_c14_strobes", {30'd0, bus.re_en, bus.wr_en}, 32'd0);
            end
        end

        // V3: fetch address after JZ, taken and not taken.
        for (int t = 0; t < 2; t++) begin
            do_reset();
            clear_mem();
            mem[0]  = enc(OpLoad, 20);
            mem[1]  = enc(OpJz, 7);
            mem[7]  = enc(OpNop, 0);
            mem[20] = (t == 0) ? 18'd0 : 18'd1;
            rst = 1'b0;
            #1;
            repeat (7) step();
            check((t == 0) ? "v3_jz_taken_fetch" : "v3_jz_fall_fetch", 32'(bus.address),
                  (t == 0) ? 32'd7 : 32'd2);
            check("v3_fetch_re", 32'(bus.re_en), 32'd1);
        end

        // V4: JMP to the last address, NOP there, pc wraps to 0.
        do_reset();
        clear_mem();
        mem[0]    = enc(OpJmp, 13'h1FFF);
        mem[8191] = enc(OpNop, 0);
        rst = 1'b0;
        #1;
        repeat (3) step();
        check("v4_fetch_top", 32'(bus.address), 32'h1FFF);
        repeat (3) step();
        check("v4_wrap_addr", 32'(bus.address), 32'd0);
        check("v4_wrap_pc", 32'(pc), 32'd0);

        // V5: reset pulsed during the STORE execute cycle aborts the write.
        do_reset();
        clear_mem();
        mem[0]  = enc(OpLoad, 13);
        mem[1]  = enc(OpStore, 15);
        mem[13] = 18'd42;
        mem[15] = 18'h01234;
        rst = 1'b0;
        #1;
        repeat (6) step();
        check("v5_store_cycle_wr", 32'(bus.wr_en), 32'd1);
        rst = 1'b1;
        #1;
        check("v5_rst_wr", 32'(bus.wr_en), 32'd0);
        check("v5_rst_re", 32'(bus.re_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("v5_mem_kept", 32'(mem[15]), 32'h01234);
        check("v5_fetch_addr", 32'(bus.address), 32'd0);
        check("v5_fetch_re", 32'(bus.re_en), 32'd1);
        check("v5_pc", 32'(pc), 32'd0);
        check("v5_ac", 32'(ac), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 18, memory word and accumulator width.
REQ-002 SHALL have parameter ADDR_W, default 13, memory address and program counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port address  output  ADDR_W  memory address.
REQ-006 SHALL have port DataIn  output  DATA_W  memory write data, which is the accumulator.
REQ-007 SHALL have port DataOut  input  DATA_W  memory read data, registered by memory, valid the cycle after re_en.
REQ-008 SHALL have port re_en  output  1  memory read strobe.
REQ-009 SHALL have port wr_en  output  1  memory write strobe.
REQ-010 SHALL have port pc  output  ADDR_W  current program counter (debug).
REQ-011 SHALL have port ac  output  DATA_W  accumulator (debug).
REQ-012 SHALL have port halted  output  1  high while in HALT state.

Function
REQ-013 SHALL decode instruction word as opcode = [17:15], reserved = [14:13] (ignored), operand address = [12:0].
REQ-014 SHALL implement opcodes: 000 ADD, 001 LOAD, 010 STORE, 011 SUB, 100 JMP, 101 JZ, 110 HALT, 111 NOP.
REQ-015 SHALL implement FSM states FETCH, DECODE, EXECUTE, ACCUM, HALT.
REQ-016 FETCH: re_en=1, address=pc; next state DECODE.
REQ-017 DECODE: IR<=DataOut, pc<=pc+1 (wraps 8191->0), strobes low; next state EXECUTE.
REQ-018 EXECUTE for LOAD/ADD/SUB: re_en=1, address=IR[12:0]; next state ACCUM.
REQ-019 ACCUM: LOAD ac<=DataOut; ADD ac<=ac+DataOut; SUB ac<=ac-DataOut; all results mod 2^18, carry/borrow discarded; next state FETCH.
REQ-020 EXECUTE for STORE: wr_en=1, address=IR[12:0], DataIn=ac for exactly one cycle; next state FETCH.
REQ-021 EXECUTE for JMP: pc<=IR[12:0]; next state FETCH.
REQ-022 EXECUTE for JZ: pc<=IR[12:0] if ac==0, else pc unchanged; next state FETCH.
REQ-023 EXECUTE for NOP: no strobes, no state change other than FSM; next state FETCH.
REQ-024 EXECUTE for HALT: next state HALT; HALT holds with all strobes low until rst.
REQ-025 Instruction latency SHALL be 3 cycles for STORE/JMP/JZ/NOP and 4 cycles for LOAD/ADD/SUB.
REQ-026 re_en and wr_en SHALL never be high in the same cycle.
REQ-027 address SHALL equal pc in all states except EXECUTE, where it is IR[12:0].
REQ-028 halted SHALL be high exactly while in state HALT.

Reset
REQ-029 While rst is high, re_en=0, wr_en=0, and no memory access is issued.
REQ-030 On a clock edge with rst high: pc=0, ac=0, IR=0, state=FETCH.
REQ-031 rst asserted mid-instruction, including in the STORE EXECUTE cycle, SHALL abort the instruction with no write issued; the first fetch after release is from address 0.

Structure
REQ-032 A shared package SHALL hold opcode constants, FSM state encoding, DATA_W/ADDR_W defaults, and instruction field positions.
REQ-033 The add/subtract/pass datapath SHALL be one sub-module, cu_alu, that is combinational, takes ac, operand and opcode, and returns the result.
REQ-034 Outputs re_en, wr_en and address SHALL be decoded from the registered state and IR only, with no combinational path from DataOut.

Verification
REQ-035 The bench SHALL pair the block with a 1-cycle-latency memory model and cover all of V1-V5.
V1 Program: LOAD 13, ADD 14, STORE 15, HALT with Mem[13]=42, Mem[14]=3 -> Mem[15]=45 written at cycle 11 after reset release; halted=1 from cycle 14.
V2 SUB: LOAD of 3 then SUB of 5 -> ac=0x3FFFE (wrap).
V3 JZ with ac=0 targeting 7 -> next fetch address is 7; JZ with ac=1 -> next fetch address is pc+1.
V4 JMP 8191 with a NOP at 8191 -> after that NOP, fetch address wraps to 0.
V5 rst pulsed during the STORE EXECUTE cycle -> wr_en stays 0, the memory location is unchanged, and the next fetch is from address 0.
V6 In every test, assert re_en and wr_en are never both high and that strobes are low during HALT.
